// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests into a ring of reserved slots,
// and hands {instruction, pc} to decode. Redirects flush the ring and drop stale responses.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instruction,
    output logic [31:0] dec_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    // One extra bit so drop_cnt + occupancy cannot overflow.
    localparam int unsigned CW = PW + 2;

    typedef logic [PW:0] ptr_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    ptr_t             alloc_ptr_q, alloc_ptr_d;
    ptr_t             fill_ptr_q, fill_ptr_d;
    ptr_t             head_ptr_q, head_ptr_d;
    ptr_t             drop_cnt_q, drop_cnt_d;
    logic [31:0]      slot_pc_q [DEPTH];
    logic [31:0]      slot_pc_d [DEPTH];
    logic [31:0]      slot_instr_q [DEPTH];
    logic [31:0]      slot_instr_d [DEPTH];
    logic [DEPTH-1:0] slot_filled_q, slot_filled_d;

    logic [PW-1:0]    head_idx, alloc_idx, fill_idx;
    logic [CW-1:0]    alloc_cnt, occupancy;
    logic             pop, req_fire, resp_drop, resp_fill;
    logic [1:0]       unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    assign head_idx  = head_ptr_q[PW-1:0];
    assign alloc_idx = alloc_ptr_q[PW-1:0];
    assign fill_idx  = fill_ptr_q[PW-1:0];

    assign dec_valid       = !rst && !redirect_valid && slot_filled_q[head_idx]
                             && (head_ptr_q != alloc_ptr_q);
    assign dec_instruction = dec_valid ? slot_instr_q[head_idx] : 32'h0;
    assign dec_pc          = dec_valid ? slot_pc_q[head_idx] : 32'h0;
    assign pop             = dec_valid && dec_ready;

    // A slot popped this cycle can be re-allocated at the same edge, which keeps a
    // 1-cycle memory streaming at one instruction per cycle with only two slots.
    assign alloc_cnt = CW'(ptr_t'(alloc_ptr_q - head_ptr_q));
    assign occupancy = alloc_cnt - CW'(pop);

    assign imem_addr      = fetch_pc_q;
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < CW'(DEPTH))
                            && ((CW'(drop_cnt_q) + occupancy) < CW'(DEPTH));

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_fill = imem_resp_valid && (drop_cnt_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        head_ptr_d    = head_ptr_q;
        drop_cnt_d    = drop_cnt_q;
        slot_pc_d     = slot_pc_q;
        slot_instr_d  = slot_instr_q;
        slot_filled_d = slot_filled_q;

        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            fill_ptr_d    = alloc_ptr_q;
            head_ptr_d    = alloc_ptr_q;
            slot_filled_d = '0;
            // Every unfilled slot still owes a response; one arriving now is consumed here.
            drop_cnt_d    = drop_cnt_q + (alloc_ptr_q - fill_ptr_q) - ptr_t'(imem_resp_valid);
        end else begin
            if (pop) begin
                slot_filled_d[head_idx] = 1'b0;
                head_ptr_d              = head_ptr_q + ptr_t'(1);
            end
            if (req_fire) begin
                slot_pc_d[alloc_idx]     = fetch_pc_q;
                slot_filled_d[alloc_idx] = 1'b0;
                alloc_ptr_d              = alloc_ptr_q + ptr_t'(1);
                fetch_pc_d               = fetch_pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - ptr_t'(1);
            end
            if (resp_fill) begin
                slot_instr_d[fill_idx]  = imem_resp_data;
                slot_filled_d[fill_idx] = 1'b1;
                fill_ptr_d              = fill_ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            head_ptr_q    <= '0;
            drop_cnt_q    <= '0;
            slot_pc_q     <= '{default: '0};
            slot_instr_q  <= '{default: '0};
            slot_filled_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            head_ptr_q    <= head_ptr_d;
            drop_cnt_q    <= drop_cnt_d;
            slot_pc_q     <= slot_pc_d;
            slot_instr_q  <= slot_instr_d;
            slot_filled_q <= slot_filled_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against an abstract fetch/delivery model driving an in-order memory queue.
module tb_instruction_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data, redirect_pc, dec_instruction, dec_pc;
    logic        redirect_valid, dec_valid, dec_ready;

    logic        w_rst, w_req_valid, w_resp_valid, w_dv;
    logic        w_req_ready = 1'b1;
    logic        w_redir = 1'b0;
    logic        w_dec_ready = 1'b1;
    logic [31:0] w_addr, w_resp_data, w_instr, w_pc;
    logic [31:0] w_redir_pc = 32'h0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instruction(dec_instruction), .dec_pc(dec_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_addr(w_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .dec_valid(w_dv), .dec_ready(w_dec_ready),
        .dec_instruction(w_instr), .dec_pc(w_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        memq[$];
    logic [31:0] w_log[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    // Stimulus knobs set by scenarios before each cycle.
    logic        t_rst = 1'b1, t_dec_ready = 1'b1, t_req_ready = 1'b1, t_redir = 1'b0;
    logic [31:0] t_redir_pc = 32'h0;
    int          lat = 1;

    // Abstract model: next fetch address, next PC owed to decode, counts per epoch.
    bit          model_ok = 1'b0;
    logic [31:0] exp_fetch = 32'h0, exp_dec = 32'h0;
    int          occ = 0, filled = 0, epoch = 0;

    // Wrap-instance 1-cycle memory.
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = 32'h0;

    // Sampled outputs of the current cycle.
    logic        s_req, s_dv;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic cycle();
        bit   resp, e_dv, e_rv, pop, acc;
        int   stale, avail;
        req_t fr;
        rst            = t_rst;
        dec_ready      = t_dec_ready;
        imem_req_ready = t_req_ready;
        redirect_valid = t_redir && !t_rst;
        redirect_pc    = t_redir_pc;
        resp           = !t_rst && memq.size() > 0 && memq[0].due <= cyc;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? (memq[0].addr ^ KEY) : $urandom;
        w_rst          = t_rst;
        w_resp_valid   = w_pend;
        w_resp_data    = w_pend_addr ^ KEY;
        #2;
        s_req   = imem_req_valid;
        s_addr  = imem_addr;
        s_dv    = dec_valid;
        s_pc    = dec_pc;
        s_instr = dec_instruction;

        stale = 0;
        foreach (memq[i]) if (memq[i].ep != epoch) stale++;
        e_dv  = !t_rst && !redirect_valid && filled > 0;
        pop   = e_dv && t_dec_ready;
        avail = occ - (pop ? 1 : 0);
        e_rv  = !t_rst && !redirect_valid && avail < DEPTH && (stale + avail) < DEPTH;
        if (model_ok) begin
            chk("imem_addr", s_addr, exp_fetch);
            chk("imem_req_valid", s_req, e_rv);
            chk("dec_valid", s_dv, e_dv);
            chk("dec_pc", s_pc, e_dv ? exp_dec : 32'h0);
            chk("dec_instruction", s_instr, e_dv ? (exp_dec ^ KEY) : 32'h0);
        end

        acc = s_req && t_req_ready && !t_rst;
        if (t_rst) begin
            memq.delete();
            exp_fetch = 32'h0;
            exp_dec   = 32'h0;
            occ       = 0;
            filled    = 0;
            epoch++;
            model_ok  = 1'b1;
        end else if (redirect_valid) begin
            if (resp) void'(memq.pop_front());
            epoch++;
            occ       = 0;
            filled    = 0;
            exp_fetch = {t_redir_pc[31:2], 2'b00};
            exp_dec   = {t_redir_pc[31:2], 2'b00};
        end else begin
            if (resp) begin
                fr = memq.pop_front();
                if (fr.ep == epoch) filled++;
            end
            if (acc) begin
                memq.push_back('{addr: s_addr, due: cyc + lat, ep: epoch});
                exp_fetch = exp_fetch + 32'd4;
                occ++;
            end
            if (pop) begin
                exp_dec = exp_dec + 32'd4;
                occ--;
                filled--;
            end
        end

        if (!t_rst && w_dv) w_log.push_back(w_pc);
        w_pend      = w_req_valid && !t_rst;
        w_pend_addr = w_addr;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        t_rst = 1'b1;
        cycle();
        t_rst = 1'b0;
    endtask

    task automatic wait_dv(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            ok = s_dv;
        end
        chk({name, "_dv_timeout"}, 32'(ok), 32'h1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        t_dec_ready = 1'b1;
        t_req_ready = 1'b1;
        lat         = 1;

        // Reset and streaming.
        t_rst = 1'b1;
        cycle();
        chk("rst_req_valid", 32'(s_req), 32'h0);
        chk("rst_dec_valid", 32'(s_dv), 32'h0);
        cycle();
        chk("rst_imem_addr", s_addr, 32'h0);
        chk("rst_dec_pc", s_pc, 32'h0);
        t_rst = 1'b0;
        cycle();
        chk("first_req_valid", 32'(s_req), 32'h1);
        cycle();
        cycle();
        chk("stream_pc0", s_pc, 32'h0);
        chk("stream_instr0", s_instr, 32'hA5A5_0000);
        cycle();
        chk("stream_pc1", s_pc, 32'h4);
        cycle();
        chk("stream_pc2", s_pc, 32'h8);
        cycle();
        chk("stream_pc3", s_pc, 32'hC);
        chk("stream_instr3", s_instr, 32'hA5A5_000C);

        // PC wrap on the second instance, streamed alongside.
        chk("wrap_count", 32'(w_log.size() >= 3), 32'h1);
        if (w_log.size() >= 3) begin
            chk("wrap_pc0", w_log[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", w_log[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", w_log[2], 32'h0000_0000);
        end

        // Mid-run reset.
        reset_dut();
        cycle();
        chk("midrst_dec_valid", 32'(s_dv), 32'h0);
        chk("midrst_addr", s_addr, 32'h0);
        wait_dv("midrst");
        chk("midrst_first_pc", s_pc, 32'h0);

        // Backpressure.
        reset_dut();
        t_dec_ready = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_req_valid", 32'(s_req), 32'h0);
            chk("bp_dec_pc", s_pc, 32'h0);
            chk("bp_instr", s_instr, 32'hA5A5_0000);
        end
        t_dec_ready = 1'b1;
        cycle();
        chk("bp_release_pc0", s_pc, 32'h0);
        cycle();
        chk("bp_release_pc1", s_pc, 32'h4);

        // Redirect with two requests in flight, 3-cycle memory.
        reset_dut();
        lat = 3;
        cycle();
        cycle();
        t_redir    = 1'b1;
        t_redir_pc = 32'h100;
        cycle();
        t_redir = 1'b0;
        cycle();
        chk("redir_addr", s_addr, 32'h100);
        chk("redir_credit_block", 32'(s_req), 32'h0);
        wait_dv("redir");
        chk("redir_first_pc", s_pc, 32'h100);
        chk("redir_first_instr", s_instr, 32'hA5A5_0100);

        // Redirect coincident with a response, misaligned target.
        reset_dut();
        lat = 1;
        cycle();
        t_redir    = 1'b1;
        t_redir_pc = 32'h203;
        cycle();
        t_redir = 1'b0;
        cycle();
        chk("coinc_addr", s_addr, 32'h200);
        chk("coinc_req_valid", 32'(s_req), 32'h1);
        chk("coinc_dec_valid", 32'(s_dv), 32'h0);
        wait_dv("coinc");
        chk("coinc_first_pc", s_pc, 32'h200);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 3);
            t_rst       = ($urandom_range(0, 299) == 0);
            t_dec_ready = ($urandom_range(0, 3) != 0);
            t_req_ready = ($urandom_range(0, 9) < 7);
            t_redir     = ($urandom_range(0, 29) == 0);
            t_redir_pc  = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
